msrv32_dmem_arbiter: RTL
========================

Name: msrv32_dmem_arbiter

Overview:
Arbitrates the single data-memory port between NREQ requesters (requester 0 is the core load/store path; higher indices are DMA and debug). It sequences each access through a request/ready memory handshake and generates byte write masks with lane-replicated store data. It returns the raw 32-bit read word, which the downstream load unit extracts and extends using its address bits [1:0].

Parameters:
NREQ, 2, number of requesters (2..4).
TIMEOUT_CYCLES, 255, cycles in ACCESS before abort. Used only when MSRV32_DMEM_TIMEOUT_EN is defined.

Ports:
ms_riscv32_mp_clk_in  input  1  clock, rising edge.
ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low.
req_in  input  NREQ  per-requester access request; held until gnt_out.
we_in  input  NREQ  1 = store, 0 = load.
addr_in  input  32*NREQ  byte address; requester i at bits [32i+31:32i].
wdata_in  input  32*NREQ  store data, right-aligned.
size_in  input  2*NREQ  00 byte, 01 half, 10/11 word.
gnt_out  output  NREQ  one-cycle pulse: request accepted.
rvalid_out  output  NREQ  one-cycle pulse: access complete.
rdata_out  output  32  raw memory word; valid only with rvalid_out.
err_out  output  1  qualifies rvalid_out: misaligned access or timeout.
dmem_req_out  output  1  memory request.
dmem_we_out  output  1  memory write enable.
dmem_addr_out  output  32  word address: {addr[31:2], 2'b00}.
dmem_wdata_out  output  32  lane-replicated store data.
dmem_wmask_out  output  4  byte write mask; 0 for loads.
dmem_ready_in  input  1  memory accepts or completes the access this cycle.
dmem_rdata_in  input  32  memory read data; valid when dmem_ready_in=1.

Behaviour:
- All outputs are registered. Reset (asynchronous) sets state to IDLE, every output to 0, and the round-robin pointer to 0. A reset mid-access abandons the access; no rvalid_out is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req_in bit is set, the winner is the first set bit scanning from the pointer upward with wrap.
  - At the clock edge, latch the winner's we, addr, wdata and size, then pulse gnt_out[winner].
  - Aligned request: go to ACCESS and assert dmem_req_out in the same cycle as gnt_out.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0): go directly to RESP with err_out=1 and rdata_out=0. No memory access is made.
- ACCESS: dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out and dmem_wmask_out stay stable until dmem_ready_in=1.
  - On ready, capture dmem_rdata_in (loads; stores capture 0), drop dmem_req_out and go to RESP.
- RESP: pulse rvalid_out[winner] with rdata_out/err_out for one cycle, set pointer = winner+1 mod NREQ, then return to IDLE.
- Minimum latency: req_in high in cycle 0 gives gnt_out and dmem_req_out in cycle 1; ready in cycle 1 gives rvalid_out in cycle 2. Throughput is one access per 3 cycles.
- Write mask:
  - Byte: 4'b0001 << addr[1:0]; data {4{wdata[7:0]}}.
  - Half: 4'b0011 << {addr[1],1'b0}; data {2{wdata[15:0]}}.
  - Word: 4'b1111; data wdata.
- rdata_out, err_out and the dmem_* signals other than dmem_req_out hold their last values outside their valid cycles. The bench checks them only when qualified.
- Requests arriving while not in IDLE wait; they are not lost because the requester keeps req_in high. Deassertion before gnt_out is legal and withdraws the request.

Optional Feature:
MSRV32_DMEM_TIMEOUT_EN
- Defined: an 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ready. When it reaches TIMEOUT_CYCLES, drop dmem_req_out and go to RESP with err_out=1 and rdata_out=0. Ready in the same cycle as timeout wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Core load word: addr 0x100, ready immediate, dmem_rdata_in 0xDEADBEEF -> gnt_out[0] cycle 1, dmem_addr_out 0x100 with wmask 0, rvalid_out[0] cycle 2 with rdata_out 0xDEADBEEF and err_out 0.
- Byte store: addr 0x203, wdata 0x000000A5 -> dmem_addr_out 0x200, wmask 4'b1000, wdata 0xA5A5A5A5. Half store at 0x202 with 0x1234 -> wmask 4'b1100, wdata 0x12341234.
- Both requesters held high continuously, ready immediate -> grants alternate 0,1,0,1 over 4 accesses; each gets rvalid_out 2 cycles after its grant.
- Misaligned word load at 0x101 -> gnt_out then rvalid_out next cycle with err_out=1 and rdata_out 0; dmem_req_out never asserted.
- Ready held low 5 cycles -> dmem_req_out and dmem_addr_out stable for 6 cycles; async reset on cycle 3 -> all outputs 0 immediately, no rvalid_out.
- With MSRV32_DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready never asserted -> dmem_req_out drops after 4 ACCESS cycles, then rvalid_out with err_out=1.

Source files
------------

// File: rtl/msrv32_dmem_arbiter.sv
// msrv32_dmem_arbiter: shares the single data-memory port among NREQ requesters.
// Requester 0 is the core load/store path. Higher indices are DMA and debug.
// Arbitration is round-robin. Each access runs as IDLE -> ACCESS -> RESP,
// or IDLE -> RESP when the access is misaligned.
// Store data is replicated across byte lanes and a byte write mask is generated.
// The raw 32-bit read word is returned; the load unit extracts and extends it.
//
// Optional feature macro: MSRV32_DMEM_TIMEOUT_EN.
// When defined, an access that sits in ACCESS for TIMEOUT_CYCLES cycles without
// ready is aborted and answered with err_out=1.
//
// Ports:
//   ms_riscv32_mp_clk_in     clock, rising edge
//   ms_riscv32_mp_rst_n_in   async active-low reset
//   req_in/we_in/addr_in/wdata_in/size_in   per-requester access (packed by index)
//   gnt_out     one-cycle accept pulse per requester
//   rvalid_out  one-cycle completion pulse per requester
//   rdata_out   raw memory word (valid with rvalid_out)
//   err_out     misaligned or timed-out access (valid with rvalid_out)
//   dmem_*      memory request/ready handshake
module msrv32_dmem_arbiter #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_n_in,
    input  logic [NREQ-1:0]     req_in,
    input  logic [NREQ-1:0]     we_in,
    input  logic [32*NREQ-1:0]  addr_in,
    input  logic [32*NREQ-1:0]  wdata_in,
    input  logic [2*NREQ-1:0]   size_in,
    output logic [NREQ-1:0]     gnt_out,
    output logic [NREQ-1:0]     rvalid_out,
    output logic [31:0]         rdata_out,
    output logic                err_out,
    output logic                dmem_req_out,
    output logic                dmem_we_out,
    output logic [31:0]         dmem_addr_out,
    output logic [31:0]         dmem_wdata_out,
    output logic [3:0]          dmem_wmask_out,
    input  logic                dmem_ready_in,
    input  logic [31:0]         dmem_rdata_in
);

    localparam int unsigned PTR_W = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Reject parameter values the design does not support.
    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("msrv32_dmem_arbiter: unsupported NREQ or TIMEOUT_CYCLES");
    end

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  winner;

`ifdef MSRV32_DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
    logic [CNT_W-1:0]  tmo_cnt;
`endif

    logic              win_found_c;
    logic [PTR_W-1:0]  win_idx_c;
    logic              sel_we_c;
    logic [31:0]       sel_addr_c;
    logic [31:0]       sel_wdata_c;
    logic [1:0]        sel_size_c;
    logic              misaligned_c;
    logic [3:0]        mask_c;
    logic [31:0]       wdata_rep_c;

    // Round-robin pick: first set request scanning upward from rr_ptr, with wrap.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            if (!win_found_c && req_in[(32'(rr_ptr) + off) % NREQ]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'((32'(rr_ptr) + off) % NREQ);
            end
        end
    end

    // Winner's fields, misalignment detection, and lane formatting.
    always_comb begin
        sel_we_c    = we_in[win_idx_c];
        sel_addr_c  = addr_in[32'(win_idx_c)*32 +: 32];
        sel_wdata_c = wdata_in[32'(win_idx_c)*32 +: 32];
        sel_size_c  = size_in[32'(win_idx_c)*2 +: 2];

        misaligned_c = ((sel_size_c == 2'b01) && sel_addr_c[0]) ||
                       (sel_size_c[1] && (sel_addr_c[1:0] != 2'b00));

        mask_c      = 4'b1111;
        wdata_rep_c = sel_wdata_c;
        case (sel_size_c)
            2'b00: begin
                mask_c      = 4'b0001 << sel_addr_c[1:0];
                wdata_rep_c = {4{sel_wdata_c[7:0]}};
            end
            2'b01: begin
                mask_c      = 4'b0011 << {sel_addr_c[1], 1'b0};
                wdata_rep_c = {2{sel_wdata_c[15:0]}};
            end
            default: begin
                mask_c      = 4'b1111;
                wdata_rep_c = sel_wdata_c;
            end
        endcase
    end

    // Access sequencer; every output is a register.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            winner         <= '0;
            gnt_out        <= '0;
            rvalid_out     <= '0;
            rdata_out      <= '0;
            err_out        <= 1'b0;
            dmem_req_out   <= 1'b0;
            dmem_we_out    <= 1'b0;
            dmem_addr_out  <= '0;
            dmem_wdata_out <= '0;
            dmem_wmask_out <= '0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            gnt_out <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found_c) begin
                        gnt_out <= NREQ'(1) << win_idx_c;
                        winner  <= win_idx_c;
                        if (misaligned_c) begin
                            // No memory access; answer with an error.
                            rdata_out <= '0;
                            err_out   <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            dmem_req_out   <= 1'b1;
                            dmem_we_out    <= sel_we_c;
                            dmem_addr_out  <= {sel_addr_c[31:2], 2'b00};
                            dmem_wdata_out <= wdata_rep_c;
                            dmem_wmask_out <= sel_we_c ? mask_c : 4'b0000;
                            state          <= ST_ACCESS;
`ifdef MSRV32_DMEM_TIMEOUT_EN
                            tmo_cnt        <= '0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ready takes priority over a timeout in the same cycle.
                    if (dmem_ready_in) begin
                        dmem_req_out <= 1'b0;
                        rdata_out    <= dmem_we_out ? 32'd0 : dmem_rdata_in;
                        err_out      <= 1'b0;
                        rvalid_out   <= NREQ'(1) << winner;
                        state        <= ST_RESP;
                    end
`ifdef MSRV32_DMEM_TIMEOUT_EN
                    else if (32'(tmo_cnt) + 32'd1 >= TIMEOUT_CYCLES) begin
                        dmem_req_out <= 1'b0;
                        rdata_out    <= '0;
                        err_out      <= 1'b1;
                        rvalid_out   <= NREQ'(1) << winner;
                        state        <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    // A misaligned access arrives here without a pulse yet; a memory access arrives with one.
                    if (rvalid_out == '0) begin
                        rvalid_out <= NREQ'(1) << winner;
                    end else begin
                        rvalid_out <= '0;
                        rr_ptr     <= (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
